// File: rtl/sync_mem_rdpipe.sv
// Single-clock RAM with byte-enable write port and a valid/ready read port.
// Read data passes through a READ_LATENCY pipeline into a credit-guarded show-ahead buffer.
module sync_mem_rdpipe #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 2,
   parameter int RDW_MODE     = 0,
   parameter int RSP_DEPTH    = READ_LATENCY + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/8-1:0]          wr_be,
   input  logic                             rd_req_valid,
   output logic                             rd_req_ready,
   input  logic [ADDR_WIDTH-1:0]            rd_req_addr,
   output logic                             rd_rsp_valid,
   input  logic                             rd_rsp_ready,
   output logic [DATA_WIDTH-1:0]            rd_rsp_data,
   output logic [$clog2(RSP_DEPTH+1)-1:0]   rd_outstanding
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rsp_buf [RSP_DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] push_data;
   logic [CW-1:0]         credits;
   logic [CW-1:0]         fill;
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic                  accept;
   logic                  push;
   logic                  pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign rd_req_ready   = credits < CW'(RSP_DEPTH);
   assign accept         = rd_req_valid & rd_req_ready & ~rst;
   assign rd_rsp_valid   = fill != '0;
   assign pop            = rd_rsp_valid & rd_rsp_ready;
   assign rd_rsp_data    = rd_rsp_valid ? rsp_buf[rptr] : '0;
   assign rd_outstanding = credits;

   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Write-first merges the same-edge write bytes into the sampled word.
   always_comb begin
      rd_word = mem[rd_req_addr];
      if (RDW_MODE == 1 && wr_en && wr_addr == rd_req_addr) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   credits <= credits + CW'(1);
            2'b01:   credits <= credits - CW'(1);
            default: credits <= credits;
         endcase
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_lat1
         assign push      = accept;
         assign push_data = rd_word;
      end else begin : g_pipe
         logic                  stage_v [READ_LATENCY-1];
         logic [DATA_WIDTH-1:0] stage_d [READ_LATENCY-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int unsigned i = 0; i < READ_LATENCY - 1; i++) stage_v[i] <= 1'b0;
            end else begin
               stage_v[0] <= accept;
               for (int unsigned i = 1; i < READ_LATENCY - 1; i++) stage_v[i] <= stage_v[i-1];
            end
         end

         always_ff @(posedge clk) begin
            stage_d[0] <= rd_word;
            for (int unsigned i = 1; i < READ_LATENCY - 1; i++) stage_d[i] <= stage_d[i-1];
         end

         assign push      = stage_v[READ_LATENCY-2];
         assign push_data = stage_d[READ_LATENCY-2];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         fill <= '0;
      end else begin
         if (push) begin
            rsp_buf[wptr] <= push_data;
            wptr          <= ptr_inc(wptr);
         end
         if (pop) rptr <= ptr_inc(rptr);
         case ({push, pop})
            2'b10:   fill <= fill + CW'(1);
            2'b01:   fill <= fill - CW'(1);
            default: fill <= fill;
         endcase
      end
   end

   // Credits bound in-flight reads to RSP_DEPTH, so a push into a full buffer is a logic bug.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && fill == CW'(RSP_DEPTH)));

endmodule
